spram_bank_ctrl: RTL and testbench

//  Parametrised iCE40UP single-port RAM controller: tiles 1-4 SPRAM256KA macros into one memory of
//  NUM_BANKS x 16K words, DATA_W 16 or 32 bits wide, behind a valid/ready request port with fixed read latency.

---
 rtl/spram_ctrl_pkg.sv | 28 ++
 rtl/spram_bank_ctrl_if.sv | 43 ++++
 rtl/spram_lane.sv | 47 ++++
 rtl/spram_bank_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_spram_bank_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and constants for the SPRAM bank controller.
//   pwr_state_t : power-manager state, also the encoding driven on pwr_state
//   SPRAM_*     : geometry of one SPRAM256KA macro (16K x 16, nibble mask)
//   cnt_width   : width of the shared idle/wake counter for a parameter set
package spram_ctrl_pkg;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    STANDBY = 2'd1,
    SLEEP   = 2'd2,
    WAKE    = 2'd3
  } pwr_state_t;

  localparam int SPRAM_ADDR_W = 14;
  localparam int SPRAM_DATA_W = 16;
  localparam int SPRAM_MASK_W = 4;

  // One counter serves the ACTIVE idle, STANDBY idle and WAKE phases, so it
  // must hold the largest of the three terminal counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spram_bank_ctrl_if.sv
// Request/response/power bundle between a buffer master and spram_bank_ctrl.
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_mask : request channel
//   rsp_valid/rsp_rdata                                     : read response
//   force_sleep                                             : sleep request level
//   pwr_state                                               : current power state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. The master holds req_valid and the request fields
// stable until that edge. req_ready depends only on registered state and
// force_sleep, never on req_valid. Reads answer with a one-cycle rsp_valid
// pulse in the cycle right after the transfer edge; rsp has no back-pressure.
// Writes produce no response.
interface spram_bank_ctrl_if #(
  parameter int DATA_W    = 16,
  parameter int NUM_BANKS = 1
);
  import spram_ctrl_pkg::*;

  localparam int ADDR_W = SPRAM_ADDR_W + $clog2(NUM_BANKS);
  localparam int MASK_W = DATA_W / 4;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_mask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              force_sleep;
  logic [1:0]        pwr_state;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask, force_sleep,
    input  req_ready, rsp_valid, rsp_rdata, pwr_state
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask, force_sleep,
    output req_ready, rsp_valid, rsp_rdata, pwr_state
  );

endinterface

// File: rtl/spram_lane.sv
// One 16-bit SPRAM256KA lane: 16K x 16 single-port array with nibble write
// mask, registered read output, STANDBY/SLEEP gating and retention.
// Written to the macro's port behaviour so iCE40 flows map it onto the
// primitive; POWEROFF_N is tied high, read-margin and test pins are tied low.
//   clk     : clock
//   addr    : macro word address
//   wdata   : write data
//   mask    : nibble write enables (1 = write)
//   cs      : chip select, access happens only when set
//   we      : 1 = write, 0 = read
//   standby : macro standby (no access, contents kept)
//   sleep   : macro sleep (no access, contents kept)
//   rdata   : read data, updated only by a read, held otherwise
module spram_lane
  import spram_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic [SPRAM_ADDR_W-1:0] addr,
  input  logic [SPRAM_DATA_W-1:0] wdata,
  input  logic [SPRAM_MASK_W-1:0] mask,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    standby,
  input  logic                    sleep,
  output logic [SPRAM_DATA_W-1:0] rdata
);

  localparam logic POWEROFF_N = 1'b1;

  logic [SPRAM_DATA_W-1:0] mem [2**SPRAM_ADDR_W];
  logic                    access;

  assign access = cs & POWEROFF_N & ~standby & ~sleep;

  always_ff @(posedge clk) begin
    if (access) begin
      if (we) begin
        for (int n = 0; n < SPRAM_MASK_W; n++) begin
          if (mask[n]) mem[addr][n*4 +: 4] <= wdata[n*4 +: 4];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spram_bank_ctrl.sv
// SPRAM bank controller: tiles NUM_BANKS x (DATA_W/16) spram_lane instances
// into one NUM_BANKS x 16K-word memory behind a valid/ready port with a fixed
// one-cycle read latency, plus idle-driven STANDBY/SLEEP power management
// and a timed WAKE phase.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : spram_bank_ctrl_if slave (request, response, force_sleep, pwr_state)
module spram_bank_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int NUM_BANKS     = 1,
  parameter int IDLE_STBY_CYC = 64,
  parameter int IDLE_SLP_CYC  = 4096,
  parameter int WAKE_CYC      = 8
) (
  input logic               clk,
  input logic               rst,
  spram_bank_ctrl_if.slave  bus
);

  localparam int LANES  = DATA_W / SPRAM_DATA_W;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = cnt_width(IDLE_STBY_CYC, IDLE_SLP_CYC, WAKE_CYC);

  generate
    if (!(DATA_W == 16 || DATA_W == 32) || NUM_BANKS < 1 ||
        NUM_BANKS * LANES > 4 || WAKE_CYC < 1) begin : g_bad_cfg
      $error("spram_bank_ctrl: unsupported DATA_W/NUM_BANKS/WAKE_CYC combination");
    end
  endgenerate

  pwr_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       accept, rd_accept;
  logic [BANK_W-1:0]          bank_idx, rd_bank_q;
  logic                       bank_ok, rd_ok_q, rd_pend_q;
  logic [DATA_W-1:0]          rd_mux, rdata_hold_q;
  logic [NUM_BANKS*DATA_W-1:0] lane_rdata;
  logic                       mac_standby, mac_sleep;

  // ---------------------------------------------------------------- decode
  generate
    if (NUM_BANKS > 1) begin : g_multi_bank
      assign bank_idx = bus.req_addr[SPRAM_ADDR_W +: BANK_W];
    end else begin : g_single_bank
      assign bank_idx = '0;
    end
    // Only a non-power-of-two bank count leaves unpopulated bank indices.
    if (NUM_BANKS == 1 || NUM_BANKS == (1 << BANK_W)) begin : g_full_map
      assign bank_ok = 1'b1;
    end else begin : g_partial_map
      assign bank_ok = (bank_idx < BANK_W'(NUM_BANKS));
    end
  endgenerate

  assign bus.req_ready = (state_q == ACTIVE) & ~bus.force_sleep;
  assign accept        = bus.req_valid & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_we;

  // Every macro shares one power state; SLEEP implies STANDBY on the macro.
  assign mac_standby = (state_q != ACTIVE);
  assign mac_sleep   = (state_q == SLEEP);

  // ----------------------------------------------------------------- lanes
  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      for (genvar l = 0; l < LANES; l++) begin : g_lane
        spram_lane u_lane (
          .clk     (clk),
          .addr    (bus.req_addr[SPRAM_ADDR_W-1:0]),
          .wdata   (bus.req_wdata[l*SPRAM_DATA_W +: SPRAM_DATA_W]),
          .mask    (bus.req_mask[l*SPRAM_MASK_W +: SPRAM_MASK_W]),
          .cs      (accept & bank_ok & (bank_idx == BANK_W'(b))),
          .we      (bus.req_we),
          .standby (mac_standby),
          .sleep   (mac_sleep),
          .rdata   (lane_rdata[b*DATA_W + l*SPRAM_DATA_W +: SPRAM_DATA_W])
        );
      end
    end
  endgenerate

  // ------------------------------------------------------------- read path
  // Lane outputs are selected by the bank captured at accept time; an
  // unpopulated bank reads as zero. The hold register keeps rsp_rdata stable
  // between responses, since lane outputs of other banks may change.
  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_ok_q && rd_bank_q == BANK_W'(b)) rd_mux = lane_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q    <= 1'b0;
      rd_bank_q    <= '0;
      rd_ok_q      <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rd_pend_q <= rd_accept;
      if (rd_accept) begin
        rd_bank_q <= bank_idx;
        rd_ok_q   <= bank_ok;
      end
      if (rd_pend_q) rdata_hold_q <= rd_mux;
    end
  end

  assign bus.rsp_valid = rd_pend_q;
  assign bus.rsp_rdata = rd_pend_q ? rd_mux : rdata_hold_q;

  // ------------------------------------------------------------- power FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts idle cycles in ACTIVE/STANDBY and elapsed cycles in WAKE;
  // it is cleared on every state change and on every accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACTIVE: begin
        if (bus.force_sleep) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = '0;
        end else if (IDLE_STBY_CYC != 0) begin
          if (cnt_q == CNT_W'(IDLE_STBY_CYC - 1)) begin
            state_d = STANDBY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STANDBY: begin
        if (bus.force_sleep) begin
          state_d = SLEEP;
          cnt_d   = '0;
        end else if (bus.req_valid) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (IDLE_SLP_CYC != 0) begin
          if (cnt_q == CNT_W'(IDLE_SLP_CYC - 1)) begin
            state_d = SLEEP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      SLEEP: begin
        if (bus.req_valid && !bus.force_sleep) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (cnt_q == CNT_W'(WAKE_CYC - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.pwr_state = state_q;

endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Directed bench for spram_bank_ctrl using three configurations:
//   dut_a : DATA_W=32, NUM_BANKS=2, power-down disabled (wide banks, masks)
//   dut_b : DATA_W=16, NUM_BANKS=1, idle 4/8, wake 3 (power FSM, reset, stream)
//   dut_c : DATA_W=16, NUM_BANKS=3, power-down disabled (nibble mask, hole bank)
module tb_spram_bank_ctrl;

  localparam int WAIT_MAX = 40;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spram_bank_ctrl_if #(.DATA_W(32), .NUM_BANKS(2)) a_if ();
  spram_bank_ctrl_if #(.DATA_W(16), .NUM_BANKS(1)) b_if ();
  spram_bank_ctrl_if #(.DATA_W(16), .NUM_BANKS(3)) c_if ();

  spram_bank_ctrl #(.DATA_W(32), .NUM_BANKS(2), .IDLE_STBY_CYC(0),
                    .IDLE_SLP_CYC(0), .WAKE_CYC(1)) dut_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave));
  spram_bank_ctrl #(.DATA_W(16), .NUM_BANKS(1), .IDLE_STBY_CYC(4),
                    .IDLE_SLP_CYC(8), .WAKE_CYC(3)) dut_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave));
  spram_bank_ctrl #(.DATA_W(16), .NUM_BANKS(3), .IDLE_STBY_CYC(0),
                    .IDLE_SLP_CYC(0), .WAKE_CYC(1)) dut_c (
    .clk(clk), .rst(rst_c), .bus(c_if.slave));

  // ------------------------------------------------------------ checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wdat(input int i);
    return {4'(i), 4'(~i), 4'(i ^ 5), 4'hA};
  endfunction

  // ------------------------------------------------------------- drivers
  // Each op starts just after a falling edge and ends just after the falling
  // edge following the accepting rising edge; for reads `data` is expected.
  task automatic a_op(input string tag, input logic we, input logic [14:0] addr,
                      input logic [31:0] data, input logic [7:0] mask);
    int n = 0;
    a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_addr = addr;
    a_if.req_wdata = we ? data : 32'h0; a_if.req_mask = mask;
    #1;
    while (!a_if.req_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, {31'b0, a_if.req_ready}, 32'd1);
    @(negedge clk);
    a_if.req_valid = 1'b0;
    if (!we) begin
      check({tag, "_vld"}, {31'b0, a_if.rsp_valid}, 32'd1);
      check(tag, a_if.rsp_rdata, data);
    end
  endtask

  task automatic b_op(input string tag, input logic we, input logic [13:0] addr,
                      input logic [15:0] data, input logic [3:0] mask);
    int n = 0;
    b_if.req_valid = 1'b1; b_if.req_we = we; b_if.req_addr = addr;
    b_if.req_wdata = we ? data : 16'h0; b_if.req_mask = mask;
    #1;
    while (!b_if.req_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, {31'b0, b_if.req_ready}, 32'd1);
    @(negedge clk);
    b_if.req_valid = 1'b0;
    if (!we) begin
      check({tag, "_vld"}, {31'b0, b_if.rsp_valid}, 32'd1);
      check(tag, {16'h0, b_if.rsp_rdata}, {16'h0, data});
    end
  endtask

  task automatic c_op(input string tag, input logic we, input logic [15:0] addr,
                      input logic [15:0] data, input logic [3:0] mask);
    int n = 0;
    c_if.req_valid = 1'b1; c_if.req_we = we; c_if.req_addr = addr;
    c_if.req_wdata = we ? data : 16'h0; c_if.req_mask = mask;
    #1;
    while (!c_if.req_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    check({tag, "_rdy"}, {31'b0, c_if.req_ready}, 32'd1);
    @(negedge clk);
    c_if.req_valid = 1'b0;
    if (!we) begin
      check({tag, "_vld"}, {31'b0, c_if.rsp_valid}, 32'd1);
      check(tag, {16'h0, c_if.rsp_rdata}, {16'h0, data});
    end
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ------------------------------------------------------------ sequence
  initial begin
    int n;
    int got;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0;
    a_if.req_wdata = '0; a_if.req_mask = '0; a_if.force_sleep = 1'b0;
    b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0;
    b_if.req_wdata = '0; b_if.req_mask = '0; b_if.force_sleep = 1'b0;
    c_if.req_valid = 1'b0; c_if.req_we = 1'b0; c_if.req_addr = '0;
    c_if.req_wdata = '0; c_if.req_mask = '0; c_if.force_sleep = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // Reset state
    check("rst_ready", {31'b0, a_if.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, a_if.rsp_valid}, 32'd0);
    check("rst_rdata", a_if.rsp_rdata, 32'd0);
    check("rst_pwr", {30'b0, a_if.pwr_state}, 32'd0);
    check("rst_pwr_b", {30'b0, b_if.pwr_state}, 32'd0);

    // 32-bit, two banks
    a_op("t1_wr_lo", 1'b1, 15'h0001, 32'h13579BDF, 8'hFF);
    a_op("t1_wr_hi", 1'b1, 15'h4001, 32'hDEADBEEF, 8'hFF);
    a_op("t1_rd_hi", 1'b0, 15'h4001, 32'hDEADBEEF, 8'h00);
    @(negedge clk);
    check("t1_pulse_end", {31'b0, a_if.rsp_valid}, 32'd0);
    check("t1_hold", a_if.rsp_rdata, 32'hDEADBEEF);
    a_op("t1_rd_lo", 1'b0, 15'h0001, 32'h13579BDF, 8'h00);
    a_op("t1_wr_full", 1'b1, 15'h4002, 32'hFFFFFFFF, 8'hFF);
    a_op("t1_wr_upper", 1'b1, 15'h4002, 32'h00000000, 8'hF0);
    a_op("t1_rd_split", 1'b0, 15'h4002, 32'h0000FFFF, 8'h00);
    a_op("t1_wr_other", 1'b1, 15'h0005, 32'h11112222, 8'hFF);
    check("t1_hold_wr", a_if.rsp_rdata, 32'h0000FFFF);
    check("t1_wr_no_rsp", {31'b0, a_if.rsp_valid}, 32'd0);

    // Nibble mask
    c_op("t2_wr_ffff", 1'b1, 16'h0010, 16'hFFFF, 4'hF);
    c_op("t2_wr_nib", 1'b1, 16'h0010, 16'h1234, 4'h2);
    c_op("t2_rd", 1'b0, 16'h0010, 16'hFF3F, 4'h0);

    // Unpopulated bank 3 with NUM_BANKS=3
    c_op("t5_wr_b2", 1'b1, 16'h8005, 16'h2222, 4'hF);
    c_op("t5_wr_b1", 1'b1, 16'h4005, 16'h1111, 4'hF);
    c_op("t5_wr_b0", 1'b1, 16'h0005, 16'h0AAA, 4'hF);
    c_op("t5_wr_hole", 1'b1, 16'hC005, 16'h9999, 4'hF);
    c_op("t5_rd_hole", 1'b0, 16'hC005, 16'h0000, 4'h0);
    c_op("t5_rd_b2", 1'b0, 16'h8005, 16'h2222, 4'h0);
    c_op("t5_rd_b1", 1'b0, 16'h4005, 16'h1111, 4'h0);
    c_op("t5_rd_b0", 1'b0, 16'h0005, 16'h0AAA, 4'h0);

    // Idle power-down, sleep and timed wake
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    b_op("t3_wr", 1'b1, 14'h0123, 16'hA5C3, 4'hF);
    repeat (3) @(negedge clk);
    check("t3_idle3_active", {30'b0, b_if.pwr_state}, 32'd0);
    @(negedge clk);
    check("t3_idle4_standby", {30'b0, b_if.pwr_state}, 32'd1);
    check("t3_stby_ready", {31'b0, b_if.req_ready}, 32'd0);
    repeat (7) @(negedge clk);
    check("t3_idle7_standby", {30'b0, b_if.pwr_state}, 32'd1);
    @(negedge clk);
    check("t3_idle8_sleep", {30'b0, b_if.pwr_state}, 32'd2);
    b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 14'h0123;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_wake", {30'b0, b_if.pwr_state}, 32'd3);
      check("t3_wake_ready", {31'b0, b_if.req_ready}, 32'd0);
      check("t3_wake_no_rsp", {31'b0, b_if.rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check("t3_active", {30'b0, b_if.pwr_state}, 32'd0);
    check("t3_active_ready", {31'b0, b_if.req_ready}, 32'd1);
    @(negedge clk);
    b_if.req_valid = 1'b0;
    check("t3_rd_vld", {31'b0, b_if.rsp_valid}, 32'd1);
    check("t3_rd_retained", {16'h0, b_if.rsp_rdata}, 32'h0000A5C3);

    // FORCE_SLEEP beats a pending request in ACTIVE
    b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 14'h0123;
    b_if.force_sleep = 1'b1;
    #1;
    check("t4_ready_forced", {31'b0, b_if.req_ready}, 32'd0);
    @(negedge clk);
    check("t4_sleep", {30'b0, b_if.pwr_state}, 32'd2);
    check("t4_no_rsp1", {31'b0, b_if.rsp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    check("t4_sleep_held", {30'b0, b_if.pwr_state}, 32'd2);
    check("t4_no_rsp2", {31'b0, b_if.rsp_valid}, 32'd0);
    b_if.force_sleep = 1'b0;
    n = 0;
    while (n < WAIT_MAX) begin
      @(negedge clk);
      n++;
      if (b_if.rsp_valid) break;
    end
    b_if.req_valid = 1'b0;
    check("t4_rsp_seen", {31'b0, b_if.rsp_valid}, 32'd1);
    check("t4_rsp_delay", n, 32'd5);
    check("t4_rd", {16'h0, b_if.rsp_rdata}, 32'h0000A5C3);

    // Reset during WAKE, then a back-to-back stream
    b_if.force_sleep = 1'b1;
    @(negedge clk);
    check("t6_sleep", {30'b0, b_if.pwr_state}, 32'd2);
    b_if.force_sleep = 1'b0;
    b_if.req_valid = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 14'h0123;
    @(negedge clk);
    check("t6_wake", {30'b0, b_if.pwr_state}, 32'd3);
    rst_b = 1'b1;
    b_if.req_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    check("t6_rst_pwr", {30'b0, b_if.pwr_state}, 32'd0);
    check("t6_rst_ready", {31'b0, b_if.req_ready}, 32'd1);
    check("t6_rst_rsp", {31'b0, b_if.rsp_valid}, 32'd0);

    got = 0;
    for (int i = 0; i < 33; i++) begin
      if (b_if.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("t6_spurious_rsp", 32'd1, 32'd0);
        end else begin
          check("t6_stream", {16'h0, b_if.rsp_rdata}, exp_q.pop_front());
          got++;
        end
      end
      if (i < 32) begin
        check("t6_stream_ready", {31'b0, b_if.req_ready}, 32'd1);
        b_if.req_valid = 1'b1;
        b_if.req_mask  = 4'hF;
        if (i < 16) begin
          b_if.req_we    = 1'b1;
          b_if.req_addr  = 14'h0100 + 14'(i);
          b_if.req_wdata = wdat(i);
        end else begin
          b_if.req_we    = 1'b0;
          b_if.req_addr  = 14'h0100 + 14'(i - 16);
          b_if.req_wdata = 16'h0;
          exp_q.push_back({16'h0, wdat(i - 16)});
        end
      end else begin
        b_if.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("t6_stream_count", got, 32'd16);
    check("t6_stream_drained", exp_q.size(), 32'd0);
    check("t6_stream_tail", {31'b0, b_if.rsp_valid}, 32'd0);

    // STANDBY wakes in one cycle on a request
    repeat (4) @(negedge clk);
    check("t6_standby", {30'b0, b_if.pwr_state}, 32'd1);
    b_op("t6_stby_rd", 1'b0, 14'h0100, wdat(0), 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
